// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and forwarding select for the multi-port register file.
package rf_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int ZERO_ADDR = 0;
  typedef enum logic [1:0] {SEL_REG, SEL_W0, SEL_W1} fwd_sel_e;
  // Port 1 outranks port 0 when both write the address being read.
  function automatic fwd_sel_e fwd_sel(input logic byp, input logic hit0, input logic hit1);
    return !byp ? SEL_REG : hit1 ? SEL_W1 : hit0 ? SEL_W0 : SEL_REG;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits set by reserve, cleared by writeback, two read ports.
module rf_scoreboard import rf_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rsv_i,
  input  logic [ADDR_W-1:0] rsv_reg_i,
  input  logic              rel0_i,
  input  logic [ADDR_W-1:0] rel0_reg_i,
  input  logic              rel1_i,
  input  logic [ADDR_W-1:0] rel1_reg_i,
  input  logic [ADDR_W-1:0] src_a_i,
  input  logic [ADDR_W-1:0] src_b_i,
  input  logic              fwd_a_i,
  input  logic              fwd_b_i,
  output logic              busy_a_o,
  output logic              busy_b_o
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DEPTH-1:0] busy_q, busy_d;
  // Reserve is applied last so a new producer outlives a same-cycle release.
  always_comb begin
    busy_d = busy_q;
    if (rel0_i) busy_d[rel0_reg_i] = 1'b0;
    if (rel1_i) busy_d[rel1_reg_i] = 1'b0;
    if (rsv_i) busy_d[rsv_reg_i] = 1'b1;
  end
  always_ff @(posedge clk) busy_q <= rst ? '0 : busy_d;
  assign busy_a_o = !rst && busy_q[src_a_i] && !fwd_a_i;
  assign busy_b_o = !rst && busy_q[src_b_i] && !fwd_b_i;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: 2R2W register file with write-through bypass, optional zero register and busy scoreboard.
module reg_file_mp import rf_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RegWrite0,
  input  logic [ADDR_W-1:0] writeReg0,
  input  logic [WIDTH-1:0]  writeValue0,
  input  logic              RegWrite1,
  input  logic [ADDR_W-1:0] writeReg1,
  input  logic [WIDTH-1:0]  writeValue1,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reserveReg,
  output logic [WIDTH-1:0]  ReadA,
  output logic [WIDTH-1:0]  ReadB,
  output logic              BusyA,
  output logic              BusyB
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic we0, we1, rsv;
  logic [ADDR_W-1:0] src [2];
  logic [WIDTH-1:0] rd [2];
  logic fwd [2];
  // Writes and reserves aimed at a hardwired zero register are squashed here.
  assign we0 = RegWrite0 && !(ZERO_REG != 0 && writeReg0 == ZA);
  assign we1 = RegWrite1 && !(ZERO_REG != 0 && writeReg1 == ZA);
  assign rsv = reserve && !(ZERO_REG != 0 && reserveReg == ZA);
  always_comb begin
    regs_d = regs_q;
    if (we0) regs_d[writeReg0] = writeValue0;
    if (we1) regs_d[writeReg1] = writeValue1;
  end
  always_ff @(posedge CLK) begin
    if (RST) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
  assign src = '{srcA, srcB};
  for (genvar p = 0; p < 2; p++) begin : g_rd
    fwd_sel_e sel;
    assign sel = fwd_sel(BYPASS != 0, we0 && writeReg0 == src[p], we1 && writeReg1 == src[p]);
    assign fwd[p] = sel != SEL_REG;
    assign rd[p] = (RST || (ZERO_REG != 0 && src[p] == ZA)) ? '0
                 : sel == SEL_W1 ? writeValue1
                 : sel == SEL_W0 ? writeValue0
                 : regs_q[src[p]];
  end
  assign ReadA = rd[0];
  assign ReadB = rd[1];
  rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk       (CLK),
    .rst       (RST),
    .rsv_i     (rsv),
    .rsv_reg_i (reserveReg),
    .rel0_i    (we0),
    .rel0_reg_i(writeReg0),
    .rel1_i    (we1),
    .rel1_reg_i(writeReg1),
    .src_a_i   (srcA),
    .src_b_i   (srcB),
    .fwd_a_i   (fwd[0]),
    .fwd_b_i   (fwd[1]),
    .busy_a_o  (BusyA),
    .busy_b_o  (BusyB)
  );
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboarded random/directed bench over two configurations (bypass+zero reg, neither).
module tb_reg_file_mp;
  typedef struct packed {
    logic [15:0] ra;
    logic [15:0] rb;
    logic ba;
    logic bb;
  } exp_t;
  logic CLK = 1'b0, RST = 1'b1;
  logic RegWrite0 = 1'b0, RegWrite1 = 1'b0, reserve = 1'b0;
  logic [3:0] writeReg0 = '0, writeReg1 = '0, srcA = '0, srcB = '0, reserveReg = '0;
  logic [15:0] writeValue0 = '0, writeValue1 = '0;
  logic [15:0] ra0, rb0, ra1, rb1;
  logic ba0, bb0, ba1, bb1;
  logic [15:0] m_reg [2][16];
  logic m_busy [2][16];
  int byp_c [2] = '{1, 0};
  int zr_c [2] = '{1, 0};
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t e0, e1;
  int checks = 0, passed = 0;

  always #5 CLK = ~CLK;

  reg_file_mp #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .CLK(CLK), .RST(RST),
    .RegWrite0(RegWrite0), .writeReg0(writeReg0), .writeValue0(writeValue0),
    .RegWrite1(RegWrite1), .writeReg1(writeReg1), .writeValue1(writeValue1),
    .srcA(srcA), .srcB(srcB), .reserve(reserve), .reserveReg(reserveReg),
    .ReadA(ra0), .ReadB(rb0), .BusyA(ba0), .BusyB(bb0)
  );
  reg_file_mp #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .CLK(CLK), .RST(RST),
    .RegWrite0(RegWrite0), .writeReg0(writeReg0), .writeValue0(writeValue0),
    .RegWrite1(RegWrite1), .writeReg1(writeReg1), .writeValue1(writeValue1),
    .srcA(srcA), .srcB(srcB), .reserve(reserve), .reserveReg(reserveReg),
    .ReadA(ra1), .ReadB(rb1), .BusyA(ba1), .BusyB(bb1)
  );

  function automatic logic dead(int c, logic [3:0] a);
    return zr_c[c] != 0 && a == 4'd0;
  endfunction

  function automatic logic [15:0] exp_rd(int c, logic [3:0] a);
    if (RST || dead(c, a)) return 16'h0;
    if (byp_c[c] != 0 && RegWrite1 && writeReg1 == a) return writeValue1;
    if (byp_c[c] != 0 && RegWrite0 && writeReg0 == a) return writeValue0;
    return m_reg[c][a];
  endfunction

  function automatic logic exp_busy(int c, logic [3:0] a);
    if (RST || dead(c, a)) return 1'b0;
    if (byp_c[c] != 0 && ((RegWrite0 && writeReg0 == a) || (RegWrite1 && writeReg1 == a))) return 1'b0;
    return m_busy[c][a];
  endfunction

  function automatic exp_t predict(int c);
    exp_t e;
    e.ra = exp_rd(c, srcA);
    e.rb = exp_rd(c, srcB);
    e.ba = exp_busy(c, srcA);
    e.bb = exp_busy(c, srcB);
    return e;
  endfunction

  task automatic update(int c);
    if (RST) begin
      for (int i = 0; i < 16; i++) begin
        m_reg[c][i] = 16'h0;
        m_busy[c][i] = 1'b0;
      end
    end else begin
      if (RegWrite0 && !dead(c, writeReg0)) begin
        m_reg[c][writeReg0] = writeValue0;
        m_busy[c][writeReg0] = 1'b0;
      end
      if (RegWrite1 && !dead(c, writeReg1)) begin
        m_reg[c][writeReg1] = writeValue1;
        m_busy[c][writeReg1] = 1'b0;
      end
      if (reserve && !dead(c, reserveReg)) m_busy[c][reserveReg] = 1'b1;
    end
  endtask

  task automatic step(input logic rst, input logic w0, input logic [3:0] a0, input logic [15:0] v0,
                      input logic w1, input logic [3:0] a1, input logic [15:0] v1,
                      input logic [3:0] sa, input logic [3:0] sb, input logic res, input logic [3:0] rr);
    @(posedge CLK);
    #1;
    RST = rst;
    RegWrite0 = w0; writeReg0 = a0; writeValue0 = v0;
    RegWrite1 = w1; writeReg1 = a1; writeValue1 = v1;
    srcA = sa; srcB = sb; reserve = res; reserveReg = rr;
    q0.push_back(predict(0));
    q1.push_back(predict(1));
    update(0);
    update(1);
  endtask

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) $display("FAIL %s actual=%h required=%h t=%0t", n, act, req, $time);
    else passed++;
  endtask

  always @(negedge CLK) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      chk("bypZ.ReadA", ra0, e0.ra);
      chk("bypZ.ReadB", rb0, e0.rb);
      chk("bypZ.BusyA", {15'h0, ba0}, {15'h0, e0.ba});
      chk("bypZ.BusyB", {15'h0, bb0}, {15'h0, e0.bb});
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      chk("plain.ReadA", ra1, e1.ra);
      chk("plain.ReadB", rb1, e1.rb);
      chk("plain.BusyA", {15'h0, ba1}, {15'h0, e1.ba});
      chk("plain.BusyB", {15'h0, bb1}, {15'h0, e1.bb});
    end
  end

  initial begin
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 16; i++) begin
        m_reg[c][i] = 16'h0;
        m_busy[c][i] = 1'b0;
      end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Fill some registers and a busy bit, then reset for two cycles.
    step(0, 1, 1, 16'h0101, 1, 2, 16'h0202, 1, 2, 1, 7);
    step(0, 1, 3, 16'h0303, 1, 4, 16'h0404, 3, 7, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 3, 4, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, 0, 4'(i), 4'(15 - i), 0, 0);
    // Write r1 on port 0: bypass vs. one-cycle latency.
    step(0, 1, 1, 16'hABCD, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    // Same-address collision: port 1 wins.
    step(0, 1, 3, 16'h1111, 1, 3, 16'h2222, 3, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0);
    // Register 0 writes and reserves.
    step(0, 1, 0, 16'h2030, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 16'h4050, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reserve r5, then release via port 1 writeback.
    step(0, 0, 0, 0, 0, 0, 0, 5, 5, 1, 5);
    step(0, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0);
    step(0, 0, 0, 0, 1, 5, 16'h0F0F, 5, 5, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0);
    // Reserve and write r6 together: the reserve survives.
    step(0, 1, 6, 16'h6666, 0, 0, 0, 6, 6, 1, 6);
    step(0, 0, 0, 0, 0, 0, 0, 6, 6, 0, 0);
    // Disabled write to r2 changes nothing; reserve an already busy reg.
    step(0, 0, 0, 0, 0, 0, 0, 2, 6, 1, 2);
    step(0, 0, 2, 16'hDEAD, 0, 2, 16'hBEEF, 2, 6, 1, 6);
    step(0, 0, 0, 0, 0, 0, 0, 2, 6, 0, 0);
    for (int n = 0; n < 500; n++) begin
      logic [3:0] a0, a1;
      a0 = 4'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom_range(0, 15));
      step($urandom_range(0, 49) == 0,
           1'($urandom_range(0, 1)), a0, 16'($urandom),
           1'($urandom_range(0, 1)), a1, 16'($urandom),
           ($urandom_range(0, 2) == 0) ? a0 : 4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0) ? a1 : 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge CLK);
    #1;
    if (q0.size() > 0 || q1.size() > 0) begin
      checks++;
      $display("FAIL drain actual=%0d pending required=0", q0.size() + q1.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
